// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Shared definitions for the sequential ALU: opcode encodings,
//                FSM state encoding, NZCV flag bit positions and the barrel
//                shifter operation kinds.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MOV = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_ORR = 4'b0101;
    localparam logic [3:0] OP_EOR = 4'b0110;
    localparam logic [3:0] OP_CLR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1010;
    localparam logic [3:0] OP_LSR = 4'b1011;
    localparam logic [3:0] OP_ASR = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions inside the {N,Z,C,V} status vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_t;

    // Maps an ALU opcode onto the shifter operation; non-shift opcodes map
    // to LSL, whose result is simply not selected.
    function automatic shift_t shift_kind(input logic [3:0] op);
        case (op)
            OP_LSR:  return SH_LSR;
            OP_ASR:  return SH_ASR;
            OP_ROR:  return SH_ROR;
            default: return SH_LSL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_unit_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter
//  Description : Combinational LSL/LSR/ASR/ROR with ARM-style carry-out.
//                A zero shift amount passes the data through and returns the
//                incoming carry unchanged.
//  Ports       : i_kind  - shift operation
//                i_data  - value to shift
//                i_amt   - shift amount, 0..W-1
//                i_carry - current C flag
//                o_data  - shifted value
//                o_carry - last bit shifted out (or i_carry when i_amt==0)
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter
    import seq_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  shift_t               i_kind,
    input  logic [W-1:0]         i_data,
    input  logic [$clog2(W)-1:0] i_amt,
    input  logic                 i_carry,
    output logic [W-1:0]         o_data,
    output logic                 o_carry
);

    // One guard bit beyond the data catches the final bit shifted out.
    logic [W:0] w_lsl;
    logic [W:0] w_lsr;
    logic [W:0] w_asr;

    assign w_lsl = {1'b0, i_data} << i_amt;
    assign w_lsr = {i_data, 1'b0} >> i_amt;
    assign w_asr = (W+1)'($signed({i_data, 1'b0}) >>> i_amt);

    always_comb begin
        o_data  = i_data;
        o_carry = i_carry;
        if (i_amt != '0) begin
            case (i_kind)
                SH_LSL: begin
                    o_data  = w_lsl[W-1:0];
                    o_carry = w_lsl[W];
                end
                SH_LSR: begin
                    o_data  = w_lsr[W:1];
                    o_carry = w_lsr[0];
                end
                SH_ASR: begin
                    o_data  = w_asr[W:1];
                    o_carry = w_asr[0];
                end
                default: begin
                    // Rotate: the last bit rotated out lands in the MSB.
                    o_data  = (i_data >> i_amt) | (i_data << (W - int'(i_amt)));
                    o_carry = o_data[W-1];
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_unit
//  Description : Multi-cycle ALU for the ARM datapath. Adder, logic unit,
//                barrel shifter, iterative shift-add multiplier and an NZCV
//                flag register behind a valid/ready handshake.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                in_valid / in_ready - operand handshake (ready only in IDLE)
//                OpSel, In1, In2     - opcode and operands
//                set_flags           - write NZCV when this op completes
//                out_valid           - one-cycle pulse, Out holds new result
//                Out                 - registered result
//                Status              - {N,Z,C,V}
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_unit
    import seq_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   OpSel,
    input  logic [W-1:0] In1,
    input  logic [W-1:0] In2,
    input  logic         set_flags,
    output logic         out_valid,
    output logic [W-1:0] Out,
    output logic [3:0]   Status
);

    localparam int SHW = $clog2(W);

    state_t         r_state;
    state_t         w_state_next;

    // Captured operation. During MUL r_a/r_b double as multiplicand
    // (shifted left) and multiplier (shifted right).
    logic [3:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_sf;
    logic           r_pend;      // single-cycle op waiting to complete
    logic [W-1:0]   r_acc;
    logic [SHW-1:0] r_count;

    logic           w_accept;
    logic           w_mul_done;
    logic           w_done;
    logic           w_sub;
    logic [W-1:0]   w_b_op;
    logic [W:0]     w_sum;
    logic           w_v;
    logic [W-1:0]   w_acc_next;
    logic [W-1:0]   w_sh_res;
    logic           w_sh_carry;
    logic [W-1:0]   w_res;
    logic           w_defined;
    logic [3:0]     w_status_next;

    assign in_ready   = (r_state == ST_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_mul_done = (r_state == ST_MUL) && (r_count == '0);
    assign w_done     = r_pend | w_mul_done;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid && OpSel == OP_MUL) w_state_next = ST_MUL;
            ST_MUL:  if (r_count == '0)               w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- arithmetic
    assign w_sub  = (r_op == OP_SUB);
    assign w_b_op = r_b ^ {W{w_sub}};
    assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + {{W{1'b0}}, w_sub};
    assign w_v    = (r_a[W-1] == w_b_op[W-1]) && (w_sum[W-1] != r_a[W-1]);

    // Partial product for the current multiplier bit; on the last cycle this
    // is already the final product, so it feeds Out directly.
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

    barrel_shifter #(.W(W)) u_shifter (
        .i_kind  (shift_kind(r_op)),
        .i_data  (r_a),
        .i_amt   (r_b[SHW-1:0]),
        .i_carry (Status[FLAG_C]),
        .o_data  (w_sh_res),
        .o_carry (w_sh_carry)
    );

    always_comb begin
        w_res         = '0;
        w_defined     = 1'b1;
        w_status_next = Status;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_res                 = w_sum[W-1:0];
                w_status_next[FLAG_C] = w_sum[W];
                w_status_next[FLAG_V] = w_v;
            end
            OP_MOV:  w_res = r_b;
            OP_AND:  w_res = r_a & r_b;
            OP_ORR:  w_res = r_a | r_b;
            OP_EOR:  w_res = r_a ^ r_b;
            OP_CLR:  w_res = '0;
            OP_MUL:  w_res = w_acc_next;
            OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
                w_res                 = w_sh_res;
                w_status_next[FLAG_C] = w_sh_carry;
            end
            default: w_defined = 1'b0;
        endcase
        if (w_defined) begin
            w_status_next[FLAG_N] = w_res[W-1];
            w_status_next[FLAG_Z] = ~|w_res;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            Out       <= '0;
            Status    <= '0;
            r_pend    <= 1'b0;
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_sf      <= 1'b0;
            r_acc     <= '0;
            r_count   <= '0;
        end else begin
            out_valid <= w_done;
            if (w_done) begin
                Out <= w_res;
                if (r_sf) Status <= w_status_next;
            end

            r_pend <= w_accept && (OpSel != OP_MUL);

            if (w_accept) begin
                r_op  <= OpSel;
                r_a   <= In1;
                r_b   <= In2;
                r_sf  <= set_flags;
                r_acc <= '0;
                if (OpSel == OP_MUL) r_count <= SHW'(W - 1);
            end else if (r_state == ST_MUL) begin
                r_acc   <= w_acc_next;
                r_a     <= r_a << 1;
                r_b     <= r_b >> 1;
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
